// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg
// Shared definitions for the multiply/divide capable MIPS ALU:
//   - ALU_CTL_W      : width of the ALUCtl operation code
//   - ALU_* codes    : ALUCtl operation encodings used by the datapath
//   - alu_state_t    : top-level sequencing states (IDLE, MUL, DIV)
package mips_alu_pkg;

  localparam int ALU_CTL_W = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_AND   = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_OR    = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD   = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU  = 4'd3;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB   = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT   = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_MULT  = 4'd8;
  localparam logic [ALU_CTL_W-1:0] ALU_MULTU = 4'd9;
  localparam logic [ALU_CTL_W-1:0] ALU_DIV   = 4'd10;
  localparam logic [ALU_CTL_W-1:0] ALU_DIVU  = 4'd11;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR   = 4'd12;
  localparam logic [ALU_CTL_W-1:0] ALU_MFHI  = 4'd13;
  localparam logic [ALU_CTL_W-1:0] ALU_MFLO  = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } alu_state_t;

endpackage

// File: rtl/mips_muldiv_iter.sv
// mips_muldiv_iter
// Iterative one-bit-per-cycle multiply/divide engine. Signed operations are
// run on operand magnitudes and the signs are restored when the result is
// read out.
// Ports:
//   CLK, RESET  : clock and synchronous active-high reset
//   start       : load operands and begin an operation this cycle
//   is_div      : 1 = restoring divide, 0 = shift-add multiply
//   is_signed   : treat a/b as two's complement
//   a, b        : multiplicand/dividend and multiplier/divisor
//   done        : high for the single cycle in which hi/lo/dbz are final
//   hi, lo      : product halves, or remainder/quotient
//   dbz         : divide by zero detected (meaningful while done)
module mips_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mcand;
  logic             mode_div;
  logic             neg_main;
  logic             neg_rem;
  logic             dbz_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Strip the signs off signed operands so the iteration only ever sees
  // unsigned magnitudes; the most-negative value maps onto 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration step. Multiply: acc:quo is the running product shifted
  // right, with the multiplier consumed from quo[0]. Divide: acc holds the
  // partial remainder and quo shifts the dividend out of the top while
  // quotient bits shift in at the bottom. The remainder is always smaller
  // than the divisor, so only its low WIDTH bits need keeping.
  always_comb begin
    mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc, quo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand};
    div_rem   = div_shift[WIDTH-1:0] - mcand;
    if (mode_div) begin
      acc_next = div_ge ? div_rem : div_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], div_ge};
    end else begin
      acc_next = mul_sum[WIDTH:1];
      quo_next = {mul_sum[0], quo[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the finished magnitudes. The remainder follows the
  // dividend, so a zero divisor naturally hands back the original dividend
  // in hi; only the quotient has to be forced to all ones.
  always_comb begin
    prod_fix = neg_main ? -{acc, quo} : {acc, quo};
    if (mode_div) begin
      hi = neg_rem ? -acc : acc;
      lo = dbz_q ? '1 : (neg_main ? -quo : quo);
    end else begin
      hi = prod_fix[2*WIDTH-1:WIDTH];
      lo = prod_fix[WIDTH-1:0];
    end
    done = busy && (count == '0);
    dbz  = dbz_q;
  end

  // Sequencer: start loads magnitudes and the WIDTH-step counter, each busy
  // cycle with a non-zero count runs one step, and the cycle after the last
  // step is the done cycle, after which the engine goes idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy     <= 1'b0;
      count    <= '0;
      acc      <= '0;
      quo      <= '0;
      mcand    <= '0;
      mode_div <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= CNT_W'(WIDTH);
      acc      <= '0;
      quo      <= is_div ? mag_a : mag_b;
      mcand    <= is_div ? mag_b : mag_a;
      mode_div <= is_div;
      neg_main <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= is_signed && a[WIDTH-1];
      dbz_q    <= is_div && (b == '0);
    end else if (busy) begin
      if (count != '0) begin
        acc   <= acc_next;
        quo   <= quo_next;
        count <= count - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips_muldiv_alu.sv
// mips_muldiv_alu
// MIPS datapath ALU with single-cycle logic/arithmetic/compare ops and
// iterative MULT/MULTU/DIV/DIVU into HI/LO, issued over valid/ready.
// Optional build macro: MIPS_ALU_OVF_EN adds the ovf output (signed
// overflow of ADD/SUB).
// Ports:
//   CLK, RESET            : clock and synchronous active-high reset
//   in_valid / in_ready   : operation handshake, ready only while idle
//   ALUCtl, A, B          : operation code and operands
//   out_valid             : one-cycle pulse when ALUOut/Zero/HI/LO update
//   ALUOut, Zero          : registered result and its zero flag
//   HI, LO                : multiply/divide result registers
//   div_by_zero           : sticky divide-by-zero flag, cleared on accept
//   ovf (optional)        : registered signed overflow of ADD/SUB
module mips_muldiv_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = ALU_CTL_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
`ifdef MIPS_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  alu_state_t state;

  logic             accept;
  logic             is_mul_op;
  logic             is_div_op;
  logic             eng_start;
  logic             eng_signed;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic             eng_dbz;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] single_res;
`ifdef MIPS_ALU_OVF_EN
  logic             single_ovf;
`endif

  // Handshake and decode: only an idle ALU takes an op, and requests made
  // while busy are simply dropped rather than queued.
  always_comb begin
    in_ready   = (state == IDLE);
    accept     = in_valid && in_ready;
    is_mul_op  = (ALUCtl == ALU_MULT) || (ALUCtl == ALU_MULTU);
    is_div_op  = (ALUCtl == ALU_DIV) || (ALUCtl == ALU_DIVU);
    eng_signed = (ALUCtl == ALU_MULT) || (ALUCtl == ALU_DIV);
    eng_start  = accept && (is_mul_op || is_div_op);
  end

  // Single-cycle result mux. Unknown codes fall through to zero; MFHI and
  // MFLO read the registers as they stand when the op is accepted.
  always_comb begin
    add_res    = A + B;
    sub_res    = A - B;
    single_res = '0;
    case (ALUCtl)
      ALU_AND:  single_res = A & B;
      ALU_OR:   single_res = A | B;
      ALU_ADD:  single_res = add_res;
      ALU_SUB:  single_res = sub_res;
      ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_NOR:  single_res = ~(A | B);
      ALU_MFHI: single_res = HI;
      ALU_MFLO: single_res = LO;
      default:  single_res = '0;
    endcase
  end

`ifdef MIPS_ALU_OVF_EN
  // Signed overflow: operands whose signs make overflow possible, and a
  // result whose sign disagrees with A.
  always_comb begin
    single_ovf = 1'b0;
    if (ALUCtl == ALU_ADD) begin
      single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
    end else if (ALUCtl == ALU_SUB) begin
      single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
    end
  end
`endif

  mips_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (eng_start),
    .is_div   (is_div_op),
    .is_signed(eng_signed),
    .a        (A),
    .b        (B),
    .done     (eng_done),
    .hi       (eng_hi),
    .lo       (eng_lo),
    .dbz      (eng_dbz)
  );

  // Control FSM and output registers. Single-cycle ops complete in the
  // accept cycle and leave the FSM in IDLE so they can issue back to back;
  // MUL/DIV park here until the engine reports done, which is the cycle
  // the result lands in HI/LO and ready comes back.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      ALUOut      <= '0;
      Zero        <= 1'b1;
      HI          <= '0;
      LO          <= '0;
      div_by_zero <= 1'b0;
`ifdef MIPS_ALU_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef MIPS_ALU_OVF_EN
      ovf       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            if (is_mul_op) begin
              state <= MUL;
            end else if (is_div_op) begin
              state <= DIV;
            end else begin
              out_valid <= 1'b1;
              ALUOut    <= single_res;
              Zero      <= (single_res == '0);
`ifdef MIPS_ALU_OVF_EN
              ovf       <= single_ovf;
`endif
            end
          end
        end
        MUL, DIV: begin
          if (eng_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            HI        <= eng_hi;
            LO        <= eng_lo;
            ALUOut    <= eng_lo;
            Zero      <= (eng_lo == '0);
            if (state == DIV && eng_dbz) begin
              div_by_zero <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_alu.sv
module tb_mips_muldiv_alu;

  localparam int W = 32;

  localparam logic [3:0] C_AND   = 4'd0;
  localparam logic [3:0] C_OR    = 4'd1;
  localparam logic [3:0] C_ADD   = 4'd2;
  localparam logic [3:0] C_SLTU  = 4'd3;
  localparam logic [3:0] C_SUB   = 4'd6;
  localparam logic [3:0] C_SLT   = 4'd7;
  localparam logic [3:0] C_MULT  = 4'd8;
  localparam logic [3:0] C_MULTU = 4'd9;
  localparam logic [3:0] C_DIV   = 4'd10;
  localparam logic [3:0] C_DIVU  = 4'd11;
  localparam logic [3:0] C_NOR   = 4'd12;
  localparam logic [3:0] C_MFHI  = 4'd13;
  localparam logic [3:0] C_MFLO  = 4'd14;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUCtl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic [W-1:0] ALUOut;
  logic         Zero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mHi;
  logic [W-1:0] mLo;
  logic         mDbz;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expOut;
    logic         expZero;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] codes[14];

  mips_muldiv_alu #(
    .WIDTH(W),
    .CTL_W(4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUCtl     (ALUCtl),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .ALUOut     (ALUOut),
    .Zero       (Zero),
    .HI         (HI),
    .LO         (LO),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10-time-unit clock.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present one op for exactly one accept edge, then scramble the operand
  // buses so any failure to latch them shows up in the results.
  task automatic applyStimulus(input logic [3:0] ctl, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    ALUCtl   = ctl;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
  endtask

  // Count cycles from the accept edge until out_valid, bounded. With poke
  // set, stray ADD requests are raised while the ALU should be busy.
  task automatic waitDone(output int lat, input bit poke);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (poke && lat >= 2 && lat <= 5) begin
        in_valid = 1'b1;
        ALUCtl   = C_ADD;
        A        = $urandom;
        B        = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  // Reference behaviour from plain 64-bit arithmetic: products are full
  // wide multiplies, division uses the language's truncating / and %.
  function automatic void refModel(input logic [3:0] ctl, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res,
                                   output logic multi);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [63:0]        up;
    sa    = $signed(a);
    sb    = $signed(b);
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    multi = 1'b0;
    mDbz  = 1'b0;
    res   = '0;
    case (ctl)
      C_AND:  res = a & b;
      C_OR:   res = a | b;
      C_ADD:  res = a + b;
      C_SUB:  res = a - b;
      C_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      C_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      C_NOR:  res = ~(a | b);
      C_MFHI: res = mHi;
      C_MFLO: res = mLo;
      C_MULT: begin
        sp = sa * sb;
        mHi = sp[63:32];
        mLo = sp[31:0];
        multi = 1'b1;
      end
      C_MULTU: begin
        up = ua * ub;
        mHi = up[63:32];
        mLo = up[31:0];
        multi = 1'b1;
      end
      C_DIV, C_DIVU: begin
        multi = 1'b1;
        if (b == 0) begin
          mLo  = '1;
          mHi  = a;
          mDbz = 1'b1;
        end else if (ctl == C_DIV) begin
          sp  = sa / sb;
          mLo = sp[31:0];
          sp  = sa % sb;
          mHi = sp[31:0];
        end else begin
          up  = ua / ub;
          mLo = up[31:0];
          up  = ua % ub;
          mHi = up[31:0];
        end
      end
      default: res = '0;
    endcase
    if (multi) res = mLo;
  endfunction

  // Run one multi-cycle op and compare latency and all results against the
  // expected values given.
  task automatic runMulti(input string name, input logic [3:0] ctl,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                          input logic expDbz, input bit poke);
    int lat;
    applyStimulus(ctl, a, b);
    checkOutput({name, " busy ready"}, in_ready, 0);
    waitDone(lat, poke);
    checkOutput({name, " latency"}, lat, 33);
    checkOutput({name, " HI"}, HI, expHi);
    checkOutput({name, " LO"}, LO, expLo);
    checkOutput({name, " ALUOut"}, ALUOut, expLo);
    checkOutput({name, " Zero"}, Zero, (expLo == 0));
    checkOutput({name, " dbz"}, div_by_zero, expDbz);
    checkOutput({name, " ready back"}, in_ready, 1);
  endtask

  initial begin
    int          lat;
    logic        sawValid;
    logic        multi;
    logic [3:0]  ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expRes;

    RESET    = 1'b1;
    in_valid = 1'b0;
    ALUCtl   = '0;
    A        = '0;
    B        = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset ALUOut", ALUOut, 0);
    checkOutput("reset Zero", Zero, 1);
    checkOutput("reset HI", HI, 0);
    checkOutput("reset LO", LO, 0);
    checkOutput("reset dbz", div_by_zero, 0);
    RESET = 1'b0;

    vecs[0]  = '{C_ADD,  32'd3,          32'd4,          32'd7,          1'b0};
    vecs[1]  = '{C_SUB,  32'hA,          32'hA,          32'd0,          1'b1};
    vecs[2]  = '{C_SLT,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
    vecs[3]  = '{C_SLTU, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};
    vecs[4]  = '{C_AND,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0};
    vecs[5]  = '{C_OR,   32'h0F0F0000,   32'h000000F0,   32'h0F0F00F0,   1'b0};
    vecs[6]  = '{C_NOR,  32'd0,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[7]  = '{C_ADD,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1};
    vecs[8]  = '{C_SUB,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
    vecs[9]  = '{4'd5,   32'h1234,       32'h5678,       32'd0,          1'b1};
    vecs[10] = '{C_SLT,  32'h7FFFFFFF,   32'h80000000,   32'd0,          1'b1};
    vecs[11] = '{C_SLTU, 32'h7FFFFFFF,   32'h80000000,   32'd1,          1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d ALUOut", i), ALUOut, vecs[i].expOut);
      checkOutput($sformatf("vec%0d Zero", i), Zero, vecs[i].expZero);
    end

    runMulti("mult", C_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b1);
    applyStimulus(C_MFLO, 32'd0, 32'd0);
    checkOutput("mflo out_valid", out_valid, 1);
    checkOutput("mflo ALUOut", ALUOut, 32'hFFFFFFFA);
    applyStimulus(C_MFHI, 32'd0, 32'd0);
    checkOutput("mfhi ALUOut", ALUOut, 32'hFFFFFFFF);
    @(posedge CLK);
    #1;
    checkOutput("out_valid single pulse", out_valid, 0);

    runMulti("divu", C_DIVU, 32'd13, 32'd10, 32'd3, 32'd1, 1'b0, 1'b0);
    runMulti("div neg", C_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    runMulti("div minneg", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0);
    runMulti("div zero", C_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    checkOutput("dbz sticky", div_by_zero, 1);
    applyStimulus(C_ADD, 32'd1, 32'd1);
    checkOutput("dbz cleared", div_by_zero, 0);
    checkOutput("add after dbz", ALUOut, 32'd2);
    checkOutput("HI kept after add", HI, 32'h1234);

    applyStimulus(C_MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort HI", HI, 0);
    checkOutput("abort LO", LO, 0);
    checkOutput("abort ALUOut", ALUOut, 0);
    RESET = 1'b0;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort no late out_valid", sawValid, 0);

    codes = '{C_AND, C_OR, C_ADD, C_SLTU, C_SUB, C_SLT, C_NOR, C_MULT,
              C_MULTU, C_DIV, C_DIVU, C_MFHI, C_MFLO, 4'd15};
    mHi  = '0;
    mLo  = '0;
    mDbz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ctl = codes[$urandom_range(0, 13)];
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = $urandom_range(1, 20);
        2: a = 32'h80000000;
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      refModel(ctl, a, b, expRes, multi);
      applyStimulus(ctl, a, b);
      waitDone(lat, multi);
      checkOutput($sformatf("rnd%0d ctl%0d latency", i, ctl), lat, multi ? 33 : 0);
      checkOutput($sformatf("rnd%0d ctl%0d ALUOut", i, ctl), ALUOut, expRes);
      checkOutput($sformatf("rnd%0d ctl%0d Zero", i, ctl), Zero, (expRes == 0));
      checkOutput($sformatf("rnd%0d ctl%0d HI", i, ctl), HI, mHi);
      checkOutput($sformatf("rnd%0d ctl%0d LO", i, ctl), LO, mLo);
      checkOutput($sformatf("rnd%0d ctl%0d dbz", i, ctl), div_by_zero, mDbz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
